// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the CPU fetch port (read-only) and data port
// (read/write) onto a single-port 512x32 synchronous RAM, one access per cycle.
// Each access is acknowledged in the cycle after it is issued, with read data
// taken straight from the RAM output.
//
// Handshake: a requester raises *_req and holds it, along with its address and
// data, until it samples the one-cycle *_ack pulse. In the ack cycle the port is
// not eligible for a new grant, so a request still held there is not reissued.
// On the following cycle it must drop req or present a new transaction.
//
// Optional feature macro: MEM_ARB_WPROT_EN. When it is defined, data stores to
// addresses 0..WPROT_TOP still take a RAM slot, but the write strobe is
// suppressed and the ack carries d_err=1.
//
// dbg_state exposes the flight-tracking state: 0=IDLE, 1=I_FLIGHT, 2=D_FLIGHT.
module mem_port_arbiter #(
    parameter logic [8:0] WPROT_TOP = 9'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [8:0]  if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [8:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        ram_write,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_d,
    input  logic [31:0] ram_q,
    output logic [1:0]  dbg_state
);

`ifdef MEM_ARB_WPROT_EN
    localparam logic WPROT_EN = 1'b1;
`else
    localparam logic WPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_I_FLIGHT = 2'd1,
        ST_D_FLIGHT = 2'd2
    } st_t;

    st_t  st_q, st_d;
    logic last_fetch_q, last_fetch_d;  // 1: the most recent grant went to fetch
    logic err_q, err_d;                // the data access in flight was a blocked store

    logic if_elig, d_elig;
    logic grant_if, grant_d;
    logic wprot_hit;

    // A store into the protected code region; always 0 when protection is compiled out.
    assign wprot_hit = WPROT_EN && d_we && (d_addr <= WPROT_TOP);

    // Grant selection, next-state computation and RAM drive.
    always_comb begin
        st_d         = ST_IDLE;
        last_fetch_d = last_fetch_q;
        err_d        = 1'b0;
        grant_if     = 1'b0;
        grant_d      = 1'b0;
        ram_write    = 1'b0;
        ram_addr     = 9'd0;
        ram_d        = 32'd0;

        // A port is never reissued while its own ack is still pending.
        if_elig = if_req && (st_q != ST_I_FLIGHT);
        d_elig  = d_req  && (st_q != ST_D_FLIGHT);

        if (!reset) begin
            if (if_elig && d_elig) begin
                // Round robin: the port that did not win last time gets this slot.
                grant_d  = last_fetch_q;
                grant_if = !last_fetch_q;
            end else begin
                grant_if = if_elig;
                grant_d  = d_elig;
            end
        end

        if (grant_if) begin
            st_d         = ST_I_FLIGHT;
            last_fetch_d = 1'b1;
            ram_addr     = if_addr;
        end else if (grant_d) begin
            st_d         = ST_D_FLIGHT;
            last_fetch_d = 1'b0;
            ram_addr     = d_addr;
            ram_d        = d_wdata;
            ram_write    = d_we && !wprot_hit;
            err_d        = wprot_hit;
        end
    end

    // Flight state, round-robin history and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= ST_IDLE;
            last_fetch_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            last_fetch_q <= last_fetch_d;
            err_q        <= err_d;
        end
    end

    // Acks follow the flight state. Reset suppresses them at once, which discards any in-flight read.
    always_comb begin
        if_ack    = (st_q == ST_I_FLIGHT) && !reset;
        d_ack     = (st_q == ST_D_FLIGHT) && !reset;
        d_err     = d_ack && err_q;
        if_rdata  = ram_q;
        d_rdata   = ram_q;
        dbg_state = st_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model, directed scenarios with literal
// expectations, and a randomized requester phase. A behavioural reference
// model tracks which port was issued, the round-robin winner and a shadow
// memory, and it checks every DUT output on each falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        ram_write;
    logic [8:0]  ram_addr;
    logic [31:0] ram_d;
    logic [31:0] ram_q;
    logic [1:0]  dbg_state;

`ifdef MEM_ARB_WPROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_d     (ram_d),
        .ram_q     (ram_q),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Single-port RAM: synchronous read; a write leaves q unchanged.
    logic [31:0] ram_mem [512];
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_d;
        else           ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    // last_issue: 0 nothing, 1 fetch, 2 data (what went to the RAM last cycle).
    int          last_issue = 0;
    bit          last_win_fetch = 1'b1;
    bit          pend_err = 1'b0;
    bit          pend_load = 1'b0;
    logic [31:0] shadow [512];
    logic [31:0] exp_q [$];

    // scoreboard: check all outputs, then advance the model to the next cycle
    initial begin
        bit          f_el, d_el, prot;
        int          g;
        logic        e_we;
        logic [8:0]  e_addr;
        logic [31:0] e_d;
        logic        e_ifack, e_dack, e_derr;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            f_el = if_req && (last_issue != 1);
            d_el = d_req  && (last_issue != 2);
            g = 0;
            if (!reset) begin
                if (f_el && d_el) g = last_win_fetch ? 2 : 1;
                else if (f_el)    g = 1;
                else if (d_el)    g = 2;
            end
            prot   = PROT_ON && d_we && (d_addr <= 9'd63);
            e_we   = (g == 2) && d_we && !prot;
            e_addr = (g == 1) ? if_addr : (g == 2) ? d_addr : 9'd0;
            e_d    = (g == 2) ? d_wdata : 32'd0;
            e_ifack = !reset && (last_issue == 1);
            e_dack  = !reset && (last_issue == 2);
            e_derr  = e_dack && pend_err;

            check("ram_write", 32'(ram_write), 32'(e_we));
            check("ram_addr",  32'(ram_addr),  32'(e_addr));
            check("ram_d",     ram_d,          e_d);
            check("if_ack",    32'(if_ack),    32'(e_ifack));
            check("d_ack",     32'(d_ack),     32'(e_dack));
            check("d_err",     32'(d_err),     32'(e_derr));

            if (e_ifack || (e_dack && pend_load)) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    v = exp_q.pop_front();
                    if (e_ifack) check("if_rdata", if_rdata, v);
                    else         check("d_rdata",  d_rdata,  v);
                end
            end

            // advance model across the coming rising edge
            pend_err  = 1'b0;
            pend_load = 1'b0;
            if (reset) begin
                last_issue     = 0;
                last_win_fetch = 1'b1;
                exp_q.delete();
            end else begin
                last_issue = g;
                if (g == 1) begin
                    last_win_fetch = 1'b1;
                    exp_q.push_back(shadow[if_addr]);
                end else if (g == 2) begin
                    last_win_fetch = 1'b0;
                    if (!d_we) begin
                        pend_load = 1'b1;
                        exp_q.push_back(shadow[d_addr]);
                    end else if (prot) begin
                        pend_err = 1'b1;
                    end else begin
                        shadow[d_addr] = d_wdata;
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input bit want_d, input string name, output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 10) begin
            @(negedge clk);
            cycles++;
            got = want_d ? d_ack : if_ack;
        end
        if (!got) check({name, "_timeout"}, 32'(want_d ? d_ack : if_ack), 32'd1);
    endtask

    initial begin
        int  c;
        bit  ia, da;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 512; i++) ram_mem[i] = $urandom;
        ram_mem[0]   = 32'h08800002;
        ram_mem[1]   = 32'h08080000;
        ram_mem[5]   = 32'h00900001;
        ram_mem[82]  = 32'h00000026;
        ram_mem[104] = 32'h00000055;
        for (int i = 0; i < 512; i++) shadow[i] = ram_mem[i];

        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack",  32'(d_ack),  32'd0);
        check("rst_d_err",  32'(d_err),  32'd0);

        // 1: single fetch from address 0
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 9'd0;
        wait_ack(1'b0, "t1_if_ack", c);
        check("t1_latency", 32'(c), 32'd2);
        check("t1_if_rdata", if_rdata, 32'h08800002);
        @(posedge clk); #1;
        if_req = 1'b0;
        tick(3);

        // 2: store then load at address 200
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd200; d_wdata = 32'hDEADBEEF;
        wait_ack(1'b1, "t2_st_ack", c);
        check("t2_st_err", 32'(d_err), 32'd0);
        @(posedge clk); #1;
        d_we = 1'b0;
        wait_ack(1'b1, "t2_ld_ack", c);
        check("t2_ld_rdata", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        d_req = 1'b0;
        tick(3);

        // 3: both ports held after reset, data wins first, then strict alternation
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 9'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'd82;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t3_if_ack", 32'(if_ack), 32'((k > 0) && (k % 2 == 0)));
            check("t3_d_ack",  32'(d_ack),  32'(k % 2 == 1));
            if (k > 0 && k % 2 == 0) check("t3_if_rdata", if_rdata, 32'h08080000);
            if (k % 2 == 1)          check("t3_d_rdata",  d_rdata,  32'h00000026);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        tick(3);

        // 4: lone data requester gets every other cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'd104;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t4_d_ack", 32'(d_ack), 32'(k % 2 == 1));
            if (k % 2 == 1) check("t4_d_rdata", d_rdata, 32'h00000055);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        tick(3);

        // 5: reset right after a fetch grant discards the fetch
        if_req = 1'b1; if_addr = 9'd0;
        @(posedge clk); #1;
        reset = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t5_if_ack_n1",   32'(if_ack),    32'd0);
        check("t5_ram_write",   32'(ram_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_if_ack_n2",   32'(if_ack),    32'd0);
        check("t5_state_idle",  32'(dbg_state), 32'd0);
        tick(3);

        // 6: store into the code region, then read it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd5; d_wdata = 32'h12345678;
        wait_ack(1'b1, "t6_st_ack", c);
        check("t6_d_err", 32'(d_err), PROT_ON ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        d_we = 1'b0;
        wait_ack(1'b1, "t6_ld_ack", c);
        check("t6_rdata", d_rdata, PROT_ON ? 32'h00900001 : 32'h12345678);
        @(posedge clk); #1;
        d_req = 1'b0;
        tick(3);

        // randomized requesters with occasional reset
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            ia = if_ack;
            da = d_ack;
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                if_req = 1'b0;
                d_req = 1'b0;
            end else begin
                if ((if_req && ia && $urandom_range(0, 1) == 1) ||
                    (!if_req && $urandom_range(0, 2) == 0)) begin
                    if_req = 1'b1;
                    if_addr = 9'($urandom_range(0, 511));
                end else if (if_req && ia) begin
                    if_req = 1'b0;
                end
                if ((d_req && da && $urandom_range(0, 1) == 1) ||
                    (!d_req && $urandom_range(0, 2) == 0)) begin
                    d_req = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 80))
                                                          : 9'($urandom_range(0, 511));
                    d_wdata = $urandom;
                end else if (d_req && da) begin
                    d_req = 1'b0;
                end
            end
        end
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        tick(4);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
